// File: rtl/sevenseg_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sevenseg_pkg : segment patterns {A..G} and scan FSM state encoding
// Revision: 1.0
// ---------------------------------------------------------------------------
package sevenseg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b0011111;
  localparam logic [6:0] SEG_C     = 7'b1001110;
  localparam logic [6:0] SEG_D     = 7'b0111101;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_F     = 7'b1000111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [0:0] {
    ST_GAP = 1'b0,
    ST_ON  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sevenseg_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sevenseg_decode : combinational hex nibble to seven-segment pattern
// Revision: 1.0
// ---------------------------------------------------------------------------
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sevenseg_scan_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sevenseg_scan_ctrl : multiplexed seven-segment scan with frame-aligned
// LOAD/ACK update. Define SEVENSEG_LZB_EN for leading-zero blanking.
// Revision: 1.0
// ---------------------------------------------------------------------------
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int NDIG = 4,
  parameter int DIV  = 50000,
  parameter int GAP  = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic [4*NDIG-1:0] data,
  input  logic [NDIG-1:0]   dp_in,
  output logic              ack,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [NDIG-1:0]   an,
  output logic              frame
);

  localparam int CNT_MAX = (DIV > GAP) ? DIV : GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = $clog2(NDIG);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);
  localparam logic [NDIG-1:0]  AN_ONE   = NDIG'(1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [4*NDIG-1:0] disp_data;
  logic [NDIG-1:0]   disp_dp;
  logic [4*NDIG-1:0] pend_data;
  logic [NDIG-1:0]   pend_dp;
  logic              pflag;

  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic [6:0]        dec_seg;
  logic              blank;
  logic [6:0]        seg_shown;
  logic              dp_shown;

  // Only one digit is lit at a time, so a single decoder serves all of them.
  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib = disp_data[4*i +: 4];
        cur_dp  = disp_dp[i];
      end
    end
  end

  sevenseg_decode u_decode (
    .hex (cur_nib),
    .seg (dec_seg)
  );

`ifdef SEVENSEG_LZB_EN
  logic zero_run;
  logic lz_hit;

  // zero_run at position i is true when nibble i and every nibble above it is 0.
  always_comb begin
    zero_run = 1'b1;
    lz_hit   = 1'b0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      zero_run = zero_run && (disp_data[4*i +: 4] == 4'h0);
      if (idx == IDX_W'(i)) lz_hit = zero_run;
    end
  end

  assign blank = lz_hit && (idx != '0) && !cur_dp;
`else
  assign blank = 1'b0;
`endif

  assign seg_shown = blank ? SEG_BLANK : dec_seg;
  assign dp_shown  = blank ? 1'b0 : cur_dp;

  // idx and disp only change when leaving ON, so the values decoded above are
  // already the ones that apply when entering ON; outputs switch with the state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_GAP;
      cnt       <= '0;
      idx       <= '0;
      disp_data <= '0;
      disp_dp   <= '0;
      pend_data <= '0;
      pend_dp   <= '0;
      pflag     <= 1'b0;
      ack       <= 1'b0;
      frame     <= 1'b0;
      seg       <= SEG_BLANK;
      dp        <= 1'b0;
      an        <= '0;
    end else begin
      ack   <= 1'b0;
      frame <= 1'b0;
      case (state)
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            state <= ST_ON;
            cnt   <= '0;
            an    <= AN_ONE << idx;
            seg   <= seg_shown;
            dp    <= dp_shown;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_ON: begin
          if (cnt == DIV_LAST) begin
            state <= ST_GAP;
            cnt   <= '0;
            an    <= '0;
            seg   <= SEG_BLANK;
            dp    <= 1'b0;
            if (idx == IDX_LAST) begin
              idx   <= '0;
              frame <= 1'b1;
              if (pflag) begin
                disp_data <= pend_data;
                disp_dp   <= pend_dp;
                pflag     <= 1'b0;
                ack       <= 1'b1;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_GAP;
          cnt   <= '0;
          an    <= '0;
          seg   <= SEG_BLANK;
          dp    <= 1'b0;
        end
      endcase
      // Placed after the commit so a load on the boundary cycle stays pending.
      if (load) begin
        pend_data <= data;
        pend_dp   <= dp_in;
        pflag     <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scan_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sevenseg_scan_ctrl : directed bench, NDIG=4 DIV=4 GAP=1 (20-cycle frame)
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_sevenseg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        load;
  logic [15:0] data;
  logic [3:0]  dp_in;
  logic        ack;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame;

  int checks = 0;
  int errors = 0;

  logic [6:0] exp_seg [4];
  logic [3:0] exp_dp;
  logic       exp_ack0;
  logic       exp_frame0;

  sevenseg_scan_ctrl #(.NDIG(4), .DIV(4), .GAP(1)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .load  (load),
    .data  (data),
    .dp_in (dp_in),
    .ack   (ack),
    .seg   (seg),
    .dp    (dp),
    .an    (an),
    .frame (frame)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic set_disp(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                          input logic [6:0] s0, input logic [3:0] dps,
                          input logic fr0, input logic ack0);
    exp_seg[0] = s0;
    exp_seg[1] = s1;
    exp_seg[2] = s2;
    exp_seg[3] = s3;
    exp_dp     = dps;
    exp_frame0 = fr0;
    exp_ack0   = ack0;
  endtask

  // Cycle c of a frame: c%5==0 is the blanking cycle, then 4 lit cycles of digit c/5.
  task automatic walk(input int from, input int to);
    for (int c = from; c <= to; c++) begin
      int k;
      logic [3:0] an_e;
      logic [6:0] seg_e;
      logic dp_e, ack_e, fr_e;
      k = c / 5;
      if (c % 5 == 0) begin
        an_e  = 4'b0000;
        seg_e = 7'b0;
        dp_e  = 1'b0;
        ack_e = (c == 0) ? exp_ack0 : 1'b0;
        fr_e  = (c == 0) ? exp_frame0 : 1'b0;
      end else begin
        an_e  = 4'b0001 << k;
        seg_e = exp_seg[k];
        dp_e  = exp_dp[k];
        ack_e = 1'b0;
        fr_e  = 1'b0;
      end
      chk($sformatf("an c%0d", c), {12'b0, an}, {12'b0, an_e});
      chk($sformatf("seg c%0d", c), {9'b0, seg}, {9'b0, seg_e});
      chk($sformatf("dp c%0d", c), {15'b0, dp}, {15'b0, dp_e});
      chk($sformatf("ack c%0d", c), {15'b0, ack}, {15'b0, ack_e});
      chk($sformatf("frame c%0d", c), {15'b0, frame}, {15'b0, fr_e});
      step();
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input int c);
    load  = 1'b1;
    data  = d;
    dp_in = p;
    walk(c, c);
    load  = 1'b0;
  endtask

  localparam logic [6:0] Z  = 7'b1111110;
  localparam logic [6:0] S1 = 7'b0110000;
  localparam logic [6:0] S2 = 7'b1101101;
  localparam logic [6:0] S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011;
  localparam logic [6:0] S5 = 7'b1011011;
  localparam logic [6:0] SA = 7'b1110111;
  localparam logic [6:0] SF = 7'b1000111;

  initial begin
    rstn  = 1'b0;
    load  = 1'b0;
    data  = 16'h0;
    dp_in = 4'h0;
    step();
    step();
    rstn = 1'b1;

    // Idle after reset: zeros shown, no frame pulse on the first frame, no ACK.
    set_disp(Z, Z, Z, Z, 4'b0000, 1'b0, 1'b0);
    walk(0, 19);
    set_disp(Z, Z, Z, Z, 4'b0000, 1'b1, 1'b0);
    walk(0, 19);

    // Mid-frame load of 12AF: current frame still zeros.
    walk(0, 7);
    do_load(16'h12AF, 4'b0100, 8);
    walk(9, 19);
    set_disp(S1, S2, SA, SF, 4'b0100, 1'b1, 1'b1);
    walk(0, 19);

    // Two loads in one frame: only the latest shows, one ACK.
    set_disp(S1, S2, SA, SF, 4'b0100, 1'b1, 1'b0);
    walk(0, 2);
    do_load(16'h1111, 4'b0000, 3);
    walk(4, 11);
    do_load(16'h2222, 4'b0000, 12);
    walk(13, 19);
    set_disp(S2, S2, S2, S2, 4'b0000, 1'b1, 1'b1);
    walk(0, 19);

    // 4444 pending, 3333 loaded on the commit cycle.
    set_disp(S2, S2, S2, S2, 4'b0000, 1'b1, 1'b0);
    walk(0, 4);
    do_load(16'h4444, 4'b0000, 5);
    walk(6, 18);
    do_load(16'h3333, 4'b0000, 19);
    set_disp(S4, S4, S4, S4, 4'b0000, 1'b1, 1'b1);
    walk(0, 19);
    set_disp(S3, S3, S3, S3, 4'b0000, 1'b1, 1'b1);
    walk(0, 6);
    do_load(16'h0050, 4'b0000, 7);
    walk(8, 19);

`ifdef SEVENSEG_LZB_EN
    set_disp(7'b0, 7'b0, S5, Z, 4'b0000, 1'b1, 1'b1);
`else
    set_disp(Z, Z, S5, Z, 4'b0000, 1'b1, 1'b1);
`endif
    walk(0, 1);
    do_load(16'h5555, 4'b1111, 2);
    walk(3, 11);

    // Reset during digit 2 with 5555 pending: discarded, no ACK.
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    set_disp(Z, Z, Z, Z, 4'b0000, 1'b0, 1'b0);
    walk(0, 19);
    set_disp(Z, Z, Z, Z, 4'b0000, 1'b1, 1'b0);
    walk(0, 19);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sevenseg_scan_ctrl.md
# sevenseg_scan_ctrl

Time-multiplexed scan controller for a multi-digit common-anode/cathode seven-segment display. It shares one hex-to-segment decoder across NDIG digits by cycling one-hot digit enables with a blanking gap between digits. New display values are accepted through a LOAD/ACK handshake and applied only at frame boundaries, so a frame never mixes old and new digits. It sits between the datapath registers that produce hex values and the board display pins.

## Interface
- NDIG, 4, number of digits scanned (2..8)
- DIV, 50000, clock cycles each digit is lit (≥1)
- GAP, 64, blanking cycles between digits, all anodes off (≥1)
- CLK  in  1  system clock, rising edge
- RSTN  in  1  synchronous active-low reset, sampled on CLK rising edge
- LOAD  in  1  single-cycle request to take DATA/DP_IN
- DATA  in  4*NDIG  hex nibbles; digit 0 = DATA[3:0] (rightmost)
- DP_IN  in  NDIG  decimal-point per digit
- ACK  out  1  one-cycle pulse: pending value now displayed
- SEG  out  7  segments {A,B,C,D,E,F,G}, active high
- DP  out  1  decimal point of current digit, active high
- AN  out  NDIG  one-hot digit enable, active high; all zero in gap
- FRAME  out  1  one-cycle pulse at each frame boundary

## Operation
- Registers: disp (4*NDIG + NDIG bits, shown), pend (same width), pflag, idx (0..NDIG-1), cnt, state.
- States: GAP (AN=0, SEG=0, DP=0) and ON (AN[idx]=1, SEG=decode(disp nibble idx), DP=disp dp bit idx).
- GAP: cnt counts 0..GAP-1; at GAP-1 → ON, cnt=0.
- ON: cnt counts 0..DIV-1; at DIV-1 → GAP, cnt=0, idx=idx+1, wrapping NDIG-1 → 0.
- Frame boundary = cycle ON exits with idx=NDIG-1. On that cycle: FRAME=1; if pflag, disp←pend, pflag←0, ACK=1.
- LOAD: pend←{DATA,DP_IN}, pflag←1. LOAD while pflag=1 overwrites pend (latest wins); only one ACK results.
- LOAD on the commit cycle: the commit uses the old pend and ACKs; the new value is captured, pflag stays 1, and it commits at the next boundary.
- Decode: 0–9 standard; A,b,C,d,E,F for 10–15 (1110111, 0011111, 1001110, 0111101, 1001111, 1000111).

## Timing
- Reset (RSTN=0 at an edge): state=GAP, cnt=0, idx=0, disp=0, pend=0, pflag=0; SEG=0, DP=0, AN=0, ACK=0, FRAME=0 from the next cycle. Reset mid-frame or with pflag set discards pend with no ACK.
- All outputs are registered. AN/SEG/DP change together on the edge after the state transition. There is never a cycle with AN≠0 and stale SEG.
- After reset release: first GAP cycles blank, then digit 0 lit for DIV cycles.
- Frame period is NDIG*(DIV+GAP) cycles. Worst-case LOAD→ACK is one frame plus 1 cycle. ACK and FRAME coincide.
- cnt width is clog2(max(DIV,GAP)). No counter overflow is permitted.

## Configuration
- SEVENSEG_LZB_EN defined: leading-zero blanking. While ON at digit idx>0, if that nibble and all higher nibbles in disp are 0 and its DP bit is 0, SEG=0 and DP=0. AN timing is unchanged. Digit 0 always shows.
- Undefined: every digit is decoded as-is (0000 shows "0").

## Structure
- sevenseg_pkg: segment pattern constants for 0–F, SEG_BLANK=7'b0, state enum {ST_GAP, ST_ON}.
- One sub-module: sevenseg_decode (combinational 4-bit → 7-bit, using package constants), instantiated once and fed by the idx-selected nibble.

## Test plan
NDIG=4, DIV=4, GAP=1, frame = 20 cycles.
- Reset then idle: AN=0000 for 1 cycle, then 0001 for 4, 0000 for 1, 0010 for 4 …; SEG=1111110 while lit; FRAME every 20 cycles; ACK never.
- LOAD DATA=16'h12AF, DP_IN=4'b0100 mid-frame: current frame still shows 0s; ACK and FRAME on the same cycle; next frame shows digit0=1000111, digit1=1110111, digit2=1101101 with DP=1, digit3=0110000.
- Two LOADs (16'h1111 then 16'h2222) in one frame: exactly one ACK; display shows 2222; 1111 is never shown.
- LOAD asserted on the commit cycle with 16'h3333 while 16'h4444 is pending: ACK now and 4444 shown; a second ACK one frame later, then 3333 shown.
- RSTN low for 1 cycle during digit 2 with a load pending: all outputs 0 next cycle; idx restarts at 0; no ACK; display reads 0000.
- With SEVENSEG_LZB_EN, DATA=16'h0050: digits 3 blanked (SEG=0 while AN=1000), digit 2 blanked, digit 1 shows 1011011, digit 0 shows 1111110. Without the macro: "0050" shown.
